// File: rtl/lmring_host.sv
// Host-side LMRING terminator: injects host commands at the ring head and returns tail packets in order.
// Optional watchdog enabled by defining LMRING_HOST_TIMEOUT_EN.

`ifndef LMRING_PKT_DEFS
`define LMRING_PKT_DEFS
`define LMRING_DATA_BITS  32
`define LMRING_BR_D       31:0
`define LMRING_BR_A       63:32
`define LMRING_BR_DM      95:64
`define LMRING_BR_COL     97:96
`define LMRING_BR_TY      100:98
`define LMRING_BR_RW      101
`define LMRING_BR_AV      102
`define LMRING_BR_SQ      110:103
`define LMRING_BR_SQ_LSB  103
`define LMRING_BR_BITS    111
`endif

module lmring_host #(
   parameter int MAX_OUTST = 4,
   parameter int SQ_BITS   = 4,
   parameter int TIMEOUT   = 1024
) (
   input  logic                         ACLK,
   input  logic                         RSTN,
   input  logic                         cmd_val,
   output logic                         cmd_rdy,
   input  logic                         cmd_rw,
   input  logic [2:0]                   cmd_ty,
   input  logic [1:0]                   cmd_col,
   input  logic [31:0]                  cmd_addr,
   input  logic [31:0]                  cmd_dm,
   input  logic [`LMRING_DATA_BITS-1:0] cmd_data,
   output logic                         lmring_hout_nemp,
   output logic [`LMRING_BR_BITS-1:0]   lmring_hout,
   input  logic                         lmring_hout_ful,
   input  logic                         lmring_hin_nemp,
   input  logic [`LMRING_BR_BITS-1:0]   lmring_hin,
   output logic                         lmring_hin_ful,
   output logic                         rsp_val,
   input  logic                         rsp_rdy,
   output logic                         rsp_rw,
   output logic [SQ_BITS-1:0]           rsp_sq,
   output logic                         rsp_av,
   output logic [`LMRING_DATA_BITS-1:0] rsp_data,
   output logic [3:0]                   outst,
   output logic                         err_seq,
   output logic                         err_tmo
);

   if (MAX_OUTST < 1 || MAX_OUTST > 15 || SQ_BITS < 1 || SQ_BITS > 8 || TIMEOUT < 1) begin : g_bad_param
      $error("lmring_host: parameter out of range");
   end

   logic                       obuf_v;
   logic [`LMRING_BR_BITS-1:0] obuf;
   logic [`LMRING_BR_BITS-1:0] cmd_pkt;
   logic [SQ_BITS-1:0]         tx_sq;
   logic [SQ_BITS-1:0]         rx_sq;
   logic [SQ_BITS-1:0]         hin_sq;
   logic [3:0]                 outst_q;
   logic                       rbuf_v;
   logic                       cmd_fire;
   logic                       ob_rel;
   logic                       hin_acc;
   logic                       rsp_fire;
   logic                       hin_unused;

   assign lmring_hout_nemp = obuf_v;
   assign lmring_hout      = obuf;
   assign outst            = outst_q;
   assign rsp_val          = rbuf_v;
   assign lmring_hin_ful   = rbuf_v && !rsp_rdy;

   assign ob_rel   = obuf_v && !lmring_hout_ful;
   assign cmd_rdy  = (!obuf_v || !lmring_hout_ful) &&
                     (({1'b0, outst_q} + {4'b0, obuf_v}) < 5'(MAX_OUTST));
   assign cmd_fire = cmd_val && cmd_rdy;
   assign hin_acc  = lmring_hin_nemp && !lmring_hin_ful;
   assign rsp_fire = rbuf_v && rsp_rdy;
   assign hin_sq   = lmring_hin[`LMRING_BR_SQ_LSB +: SQ_BITS];
   // Only some tail fields are returned to the host; the rest is ignored on purpose.
   assign hin_unused = ^lmring_hin;

   always_comb begin
      cmd_pkt                 = '0;
      cmd_pkt[`LMRING_BR_D]   = cmd_data;
      cmd_pkt[`LMRING_BR_A]   = cmd_addr;
      cmd_pkt[`LMRING_BR_DM]  = cmd_dm;
      cmd_pkt[`LMRING_BR_COL] = cmd_col;
      cmd_pkt[`LMRING_BR_TY]  = cmd_ty;
      cmd_pkt[`LMRING_BR_RW]  = cmd_rw;
      cmd_pkt[`LMRING_BR_AV]  = 1'b0;
      cmd_pkt[`LMRING_BR_SQ]  = 8'(tx_sq);
   end

   always_ff @(posedge ACLK or negedge RSTN) begin
      if (!RSTN) begin
         obuf_v <= 1'b0;
         obuf   <= '0;
         tx_sq  <= '0;
      end else if (cmd_fire) begin
         obuf_v <= 1'b1;
         obuf   <= cmd_pkt;
         tx_sq  <= tx_sq + SQ_BITS'(1);
      end else if (ob_rel) begin
         obuf_v <= 1'b0;
      end
   end

   always_ff @(posedge ACLK or negedge RSTN) begin
      if (!RSTN) begin
         outst_q <= '0;
      end else begin
         case ({ob_rel, rsp_fire})
            2'b10:   outst_q <= outst_q + 4'd1;
            2'b01:   if (outst_q != 4'd0) outst_q <= outst_q - 4'd1;
            default: outst_q <= outst_q;
         endcase
      end
   end

   always_ff @(posedge ACLK or negedge RSTN) begin
      if (!RSTN) begin
         rbuf_v   <= 1'b0;
         rsp_rw   <= 1'b0;
         rsp_sq   <= '0;
         rsp_av   <= 1'b0;
         rsp_data <= '0;
         rx_sq    <= '0;
         err_seq  <= 1'b0;
      end else begin
         if (hin_acc) begin
            rbuf_v   <= 1'b1;
            rsp_rw   <= lmring_hin[`LMRING_BR_RW];
            rsp_sq   <= hin_sq;
            rsp_av   <= lmring_hin[`LMRING_BR_AV];
            rsp_data <= lmring_hin[`LMRING_BR_D];
            rx_sq    <= rx_sq + SQ_BITS'(1);
            // Out-of-order or untracked packets are flagged but still delivered.
            if (hin_sq != rx_sq || outst_q == 4'd0) err_seq <= 1'b1;
         end else if (rsp_fire) begin
            rbuf_v <= 1'b0;
         end
      end
   end

`ifdef LMRING_HOST_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tmo_cnt;
   logic          err_tmo_q;

   always_ff @(posedge ACLK or negedge RSTN) begin
      if (!RSTN) begin
         tmo_cnt   <= '0;
         err_tmo_q <= 1'b0;
      end else begin
         if (outst_q == 4'd0 || rsp_fire) tmo_cnt <= '0;
         else if (tmo_cnt != TW'(TIMEOUT)) tmo_cnt <= tmo_cnt + TW'(1);
         if (tmo_cnt == TW'(TIMEOUT)) err_tmo_q <= 1'b1;
      end
   end

   assign err_tmo = err_tmo_q;
`else
   assign err_tmo = 1'b0;
`endif

endmodule

// File: tb/tb_lmring_host.sv
// Directed bench for lmring_host: reset, loopback ordering, backpressure, SQ wrap/mismatch, watchdog.

`ifndef LMRING_PKT_DEFS
`define LMRING_PKT_DEFS
`define LMRING_DATA_BITS  32
`define LMRING_BR_D       31:0
`define LMRING_BR_A       63:32
`define LMRING_BR_DM      95:64
`define LMRING_BR_COL     97:96
`define LMRING_BR_TY      100:98
`define LMRING_BR_RW      101
`define LMRING_BR_AV      102
`define LMRING_BR_SQ      110:103
`define LMRING_BR_SQ_LSB  103
`define LMRING_BR_BITS    111
`endif

module tb_lmring_host;
   localparam int MAXO = 4;
   localparam int BB   = `LMRING_BR_BITS;

   logic          clk = 1'b0;
   logic          rstn;
   logic          cmd_val, cmd_rdy, cmd_rw;
   logic [2:0]    cmd_ty;
   logic [1:0]    cmd_col;
   logic [31:0]   cmd_addr, cmd_dm, cmd_data;
   logic          hout_nemp, hout_ful, hin_nemp, hin_ful;
   logic [BB-1:0] hout, hin;
   logic          rsp_val, rsp_rdy, rsp_rw, rsp_av;
   logic [3:0]    rsp_sq;
   logic [31:0]   rsp_data;
   logic [3:0]    outst;
   logic          err_seq, err_tmo;

   logic          loop_en, mon_en, drv_ful, drv_nemp;
   logic [BB-1:0] drv_hin;
   logic [2:0]    d_v;
   logic [BB-1:0] d_p [3];
   logic [3:0]    tx_m;
   logic [3:0]    peak;
   logic [35:0]   exp_q[$];
   int            checks = 0;
   int            failures = 0;

   always #5 clk = ~clk;

   assign hout_ful = loop_en ? 1'b0 : drv_ful;
   assign hin_nemp = loop_en ? d_v[2] : drv_nemp;
   assign hin      = loop_en ? d_p[2] : drv_hin;

   lmring_host #(.MAX_OUTST(MAXO), .SQ_BITS(4), .TIMEOUT(16)) dut (
      .ACLK(clk), .RSTN(rstn),
      .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_rw(cmd_rw), .cmd_ty(cmd_ty),
      .cmd_col(cmd_col), .cmd_addr(cmd_addr), .cmd_dm(cmd_dm), .cmd_data(cmd_data),
      .lmring_hout_nemp(hout_nemp), .lmring_hout(hout), .lmring_hout_ful(hout_ful),
      .lmring_hin_nemp(hin_nemp), .lmring_hin(hin), .lmring_hin_ful(hin_ful),
      .rsp_val(rsp_val), .rsp_rdy(rsp_rdy), .rsp_rw(rsp_rw), .rsp_sq(rsp_sq),
      .rsp_av(rsp_av), .rsp_data(rsp_data),
      .outst(outst), .err_seq(err_seq), .err_tmo(err_tmo)
   );

   function automatic logic [BB-1:0] mk_pkt(input logic [7:0] sq, input logic av, input logic rw,
                                            input logic [31:0] a, input logic [31:0] d);
      logic [BB-1:0] p;
      p = '0;
      p[`LMRING_BR_SQ]  = sq;
      p[`LMRING_BR_AV]  = av;
      p[`LMRING_BR_RW]  = rw;
      p[`LMRING_BR_TY]  = 3'd4;
      p[`LMRING_BR_COL] = 2'd1;
      p[`LMRING_BR_DM]  = 32'hFFFF_FFFF;
      p[`LMRING_BR_A]   = a;
      p[`LMRING_BR_D]   = d;
      return p;
   endfunction

   // Three-stage ring: every stage claims the address, reads get data = ~address.
   function automatic logic [BB-1:0] ring_merge(input logic [BB-1:0] p);
      logic [BB-1:0] q;
      q = p;
      q[`LMRING_BR_AV] = 1'b1;
      if (!q[`LMRING_BR_RW]) q[`LMRING_BR_D] = ~q[`LMRING_BR_A];
      return q;
   endfunction

   always @(posedge clk) begin
      if (!rstn || !loop_en) begin
         d_v <= '0;
      end else begin
         d_v    <= {d_v[1:0], hout_nemp};
         d_p[0] <= ring_merge(hout);
         d_p[1] <= d_p[0];
         d_p[2] <= d_p[1];
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      #1;
      if (mon_en) begin
         if (rsp_val && rsp_rdy) begin
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", 1, 0);
            end else begin
               logic [35:0] e;
               e = exp_q.pop_front();
               check("rsp_sq", rsp_sq, e[35:32]);
               check("rsp_data", rsp_data, e[31:0]);
               check("rsp_av", rsp_av, 1);
            end
         end
         if (outst > peak) peak = outst;
         if (outst == 4'(MAXO)) check("rdy_at_max", cmd_rdy, 0);
      end
   end

   task automatic do_reset();
      rstn = 1'b0; cmd_val = 1'b0; drv_ful = 1'b0; drv_nemp = 1'b0; loop_en = 1'b0;
      exp_q.delete(); tx_m = '0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic send(input logic rw, input logic [31:0] addr, input logic [31:0] data);
      int n;
      cmd_rw = rw; cmd_ty = 3'd4; cmd_col = 2'd1; cmd_addr = addr;
      cmd_dm = 32'hFFFF_FFFF; cmd_data = data; cmd_val = 1'b1;
      #1;
      n = 0;
      while (!cmd_rdy && n < 200) begin
         @(negedge clk); #1; n++;
      end
      if (n == 200) check("cmd_rdy_wait", 0, 1);
      @(posedge clk);
      if (loop_en) exp_q.push_back({tx_m, rw ? data : ~addr});
      tx_m = tx_m + 4'd1;
      @(negedge clk);
      cmd_val = 1'b0;
   endtask

   task automatic inject(input logic [BB-1:0] p);
      int n;
      drv_hin = p; drv_nemp = 1'b1;
      #1;
      n = 0;
      while (hin_ful && n < 200) begin
         @(negedge clk); #1; n++;
      end
      if (n == 200) check("hin_wait", 0, 1);
      @(posedge clk);
      @(negedge clk);
      drv_nemp = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clk); n++;
      end
      check("drain", exp_q.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rstn = 1'b0; cmd_val = 1'b0; cmd_rw = 1'b0; cmd_ty = '0; cmd_col = '0;
      cmd_addr = '0; cmd_dm = '0; cmd_data = '0; loop_en = 1'b0; mon_en = 1'b0;
      rsp_rdy = 1'b0; drv_ful = 1'b0; drv_nemp = 1'b0; drv_hin = '0; tx_m = '0; peak = '0;
      repeat (3) @(negedge clk);
      check("rst_cmd_rdy", cmd_rdy, 1);
      check("rst_hout_nemp", hout_nemp, 0);
      check("rst_hout", hout, 0);
      check("rst_hin_ful", hin_ful, 0);
      check("rst_rsp_val", rsp_val, 0);
      check("rst_rsp_fields", {rsp_rw, rsp_sq, rsp_av, rsp_data}, 0);
      check("rst_outst", outst, 0);
      check("rst_err_seq", err_seq, 0);
      check("rst_err_tmo", err_tmo, 0);
      rstn = 1'b1;
      @(negedge clk);

      // first injected packet
      send(1'b0, 32'h1000, 32'h0);
      #1;
      check("first_nemp", hout_nemp, 1);
      check("first_pkt", hout, mk_pkt(8'd0, 1'b0, 1'b0, 32'h1000, 32'h0));
      @(negedge clk);
      check("first_outst", outst, 1);
      rsp_rdy = 1'b1;
      inject(mk_pkt(8'd0, 1'b1, 1'b0, 32'h1000, 32'h1234_5678));
      #1;
      check("first_rsp_val", rsp_val, 1);
      check("first_rsp", {rsp_rw, rsp_sq, rsp_av, rsp_data}, {1'b0, 4'd0, 1'b1, 32'h1234_5678});
      @(negedge clk);
      check("first_done_outst", outst, 0);
      check("first_err_seq", err_seq, 0);

      // loopback: six back-to-back commands, last one a write
      do_reset();
      rsp_rdy = 1'b1; loop_en = 1'b1; mon_en = 1'b1; peak = '0;
      for (int i = 0; i < 6; i++) send(i == 5, 32'h2000 + i * 4, 32'hC0DE_0000 + i);
      wait_drain();
      check("loop_peak", peak, 4);
      check("loop_outst", outst, 0);
      check("loop_err_seq", err_seq, 0);

      // head backpressure then tail backpressure
      loop_en = 1'b0; mon_en = 1'b0; drv_ful = 1'b1;
      send(1'b1, 32'h3000, 32'hDEAD_BEEF);
      for (int k = 0; k < 5; k++) begin
         #1;
         check("bp_hold_pkt", hout, mk_pkt(8'd6, 1'b0, 1'b1, 32'h3000, 32'hDEAD_BEEF));
         check("bp_cmd_rdy", cmd_rdy, 0);
         @(negedge clk);
      end
      drv_ful = 1'b0;
      @(negedge clk);
      check("bp_outst", outst, 1);
      check("bp_released", hout_nemp, 0);
      rsp_rdy = 1'b0;
      inject(mk_pkt(8'd6, 1'b1, 1'b1, 32'h3000, 32'hDEAD_BEEF));
      #1;
      check("bp_rsp_val", rsp_val, 1);
      check("bp_hin_ful", hin_ful, 1);
      check("bp_rsp_sq", rsp_sq, 6);
      @(negedge clk); #1;
      check("bp_rsp_held", rsp_val, 1);
      check("bp_hin_ful_held", hin_ful, 1);
      rsp_rdy = 1'b1; #1;
      check("bp_hin_ful_rel", hin_ful, 0);
      @(negedge clk);
      check("bp_pop_val", rsp_val, 0);
      check("bp_pop_outst", outst, 0);

      // 20 commands from SQ 7: wraps 15 -> 0
      loop_en = 1'b1; mon_en = 1'b1;
      for (int i = 0; i < 20; i++) send(i[0], 32'h4000 + i * 16, 32'h5000 + i);
      wait_drain();
      check("wrap_err_seq", err_seq, 0);
      check("wrap_outst", outst, 0);

      // SQ mismatch: 7 returned where 5 is expected
      do_reset();
      rsp_rdy = 1'b1; loop_en = 1'b1; mon_en = 1'b1;
      for (int i = 0; i < 5; i++) send(1'b0, 32'h6000 + i * 4, 32'h0);
      wait_drain();
      mon_en = 1'b0; loop_en = 1'b0;
      check("mis_pre_err", err_seq, 0);
      send(1'b0, 32'h7000, 32'h0);
      @(negedge clk);
      check("mis_outst", outst, 1);
      inject(mk_pkt(8'd7, 1'b1, 1'b0, 32'h7000, 32'hAAAA_5555));
      #1;
      check("mis_err_seq", err_seq, 1);
      check("mis_rsp_val", rsp_val, 1);
      check("mis_rsp", {rsp_sq, rsp_data}, {4'd7, 32'hAAAA_5555});
      repeat (3) @(negedge clk);
      check("mis_sticky", err_seq, 1);
      check("mis_outst_done", outst, 0);

      // return with nothing outstanding
      do_reset();
      check("stray_pre", err_seq, 0);
      inject(mk_pkt(8'd0, 1'b1, 1'b0, 32'h0, 32'h0));
      #1;
      check("stray_err_seq", err_seq, 1);
      check("stray_outst", outst, 0);

      // watchdog: one command that never returns
      do_reset();
      send(1'b0, 32'h8000, 32'h0);
      repeat (8) @(negedge clk);
      check("tmo_early", err_tmo, 0);
      repeat (32) @(negedge clk);
`ifdef LMRING_HOST_TIMEOUT_EN
      check("tmo_set", err_tmo, 1);
`else
      check("tmo_off", err_tmo, 0);
`endif
      check("tmo_outst", outst, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
